// File: rtl/shift_pipe2.sv
// shift_pipe2 -- two-stage 16-bit shifter/rotator with valid/ready handshake.
//
// Stage S1 applies the fine amount Cnt[1:0] (0..3); stage S2 applies the
// coarse amount 4*Cnt[3:2] (0,4,8,12) using the Op latched alongside S1.
// Out is the S2 register; out_valid is the S2 valid bit.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers In/Cnt/Op
//   in_ready   block accepts the offer this cycle
//   In  [15:0] operand
//   Cnt [3:0]  shift/rotate amount
//   Op  [1:0]  00 ROL, 01 SLL, 10 ROR, 11 SRL
//   out_valid  Out holds a completed result
//   out_ready  downstream consumes Out this cycle
//   Out [15:0] result
//
// Build option:
//   SHIFT_PIPE2_RIGHT_EN  when defined, ROR/SRL are implemented; otherwise
//                         Op[1] is ignored (10 acts as ROL, 11 as SLL).

module shift_pipe2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Out
);

`ifdef SHIFT_PIPE2_RIGHT_EN
    localparam int unsigned OPW = 2;
`else
    localparam int unsigned OPW = 1;
`endif

    // Op[0] selects logical shift (1) versus rotate (0); Op[1] selects right.
    function automatic logic [15:0] shift16(input logic [15:0]    d,
                                            input logic [3:0]     amt,
                                            input logic [OPW-1:0] op);
        logic [4:0]  inv;
        logic [15:0] res;
        // Complementary amount for the wrap-around part of a rotate;
        // amt = 0 gives inv = 16, which shifts everything out (no wrap).
        inv = 5'd16 - {1'b0, amt};
`ifdef SHIFT_PIPE2_RIGHT_EN
        if (op[1]) begin
            res = op[0] ? (d >> amt) : ((d >> amt) | (d << inv));
        end else begin
            res = op[0] ? (d << amt) : ((d << amt) | (d >> inv));
        end
`else
        res = op[0] ? (d << amt) : ((d << amt) | (d >> inv));
`endif
        return res;
    endfunction

    logic [OPW-1:0] op_in;
    logic [15:0]    s1_data;
    logic [1:0]     s1_hi;
    logic [OPW-1:0] s1_op;
    logic           v1;
    logic           v2;
    logic [15:0]    s2_data;
    logic           s1_load;
    logic           s2_load;
    logic           adv2;

    assign op_in = Op[OPW-1:0];

`ifndef SHIFT_PIPE2_RIGHT_EN
    logic unused_op1;
    assign unused_op1 = Op[1];
`endif

    // S2 can take new data when empty or draining this cycle.
    assign adv2     = v2 & out_ready;
    assign s2_load  = (~v2 | out_ready) & v1;
    assign in_ready = ~v1 | ~v2 | out_ready;
    assign s1_load  = in_valid & in_ready;

    assign out_valid = v2;
    assign Out       = s2_data;

    // Stage 1: fine shift by Cnt[1:0], carry coarse amount and op forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_data <= '0;
            s1_hi   <= '0;
            s1_op   <= '0;
        end else begin
            v1 <= s1_load | (v1 & ~s2_load);
            if (s1_load) begin
                s1_data <= shift16(In, {2'b00, Cnt[1:0]}, op_in);
                s1_hi   <= Cnt[3:2];
                s1_op   <= op_in;
            end
        end
    end

    // Stage 2: coarse shift by 4*Cnt[3:2]. A bubble arriving while S2
    // drains clears v2, so a consumed result is never re-presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            s2_data <= '0;
        end else begin
            v2 <= s2_load | (v2 & ~adv2);
            if (s2_load) begin
                s2_data <= shift16(s1_data, {s1_hi, 2'b00}, s1_op);
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe2.sv
// tb_shift_pipe2 -- self-checking bench for shift_pipe2.
// A bit-level reference model feeds an expected-result queue that is checked
// against Out on every cycle out_valid is high; directed sequences add
// hand-computed literal expectations.

module tb_shift_pipe2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] In_d;
    logic [3:0]  Cnt_d;
    logic [1:0]  Op_d;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out_d;

    always #5 clk = ~clk;

    shift_pipe2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In_d),
        .Cnt       (Cnt_d),
        .Op        (Op_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out_d)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    // Reference: move each input bit to its destination position.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] c,
                                          input logic [1:0] op);
        logic [15:0] r;
        int          j;
        bit          right;
        bit          rot;
        r = '0;
`ifdef SHIFT_PIPE2_RIGHT_EN
        right = op[1];
`else
        right = 1'b0;
`endif
        rot = (op[0] == 1'b0);
        for (int i = 0; i < 16; i++) begin
            j = right ? (i - int'(c)) : (i + int'(c));
            if (rot) begin
                j = (j + 16) % 16;
                r[j] = d[i];
            end else if (j >= 0 && j < 16) begin
                r[j] = d[i];
            end
        end
        return r;
    endfunction

    // Scoreboard / compare process.
    logic [15:0] exp_q[$];
    logic [15:0] prev_out   = '0;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) check("mon_unexpected_valid", {15'b0, out_valid}, 16'h0000);
            else check("mon_out", Out_d, exp_q[0]);
        end
        if (prev_stall) begin
            check("mon_stall_out", Out_d, prev_out);
            check("mon_stall_valid", {15'b0, out_valid}, 16'h0001);
        end
        if (rst === 1'b1) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready === 1'b1) exp_q.push_back(model(In_d, Cnt_d, Op_d));
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_out   = Out_d;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single op through an empty pipe with out_ready high.
    task automatic run_one(input string nm, input logic [15:0] d, input logic [3:0] c,
                           input logic [1:0] o, input logic [15:0] exp);
        In_d = d; Cnt_d = c; Op_d = o; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, {15'b0, in_ready}, 16'h0001);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_lat1"}, {15'b0, out_valid}, 16'h0000);
        @(negedge clk);
        check({nm, "_valid"}, {15'b0, out_valid}, 16'h0001);
        check(nm, Out_d, exp);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] got[$];
        logic [15:0] want[3];
        bit          acc;

        // Reset with traffic offered on both sides.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        In_d = 16'hFFFF; Cnt_d = 4'd1; Op_d = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        check("rst_out", Out_d, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {15'b0, in_ready}, 16'h0001);
        check("post_rst_out_valid", {15'b0, out_valid}, 16'h0000);
        tick();

        // Single-op directed vectors.
        run_one("rol_8001_1",  16'h8001, 4'd1,  2'b00, 16'h0003);
        run_one("sll_8001_4",  16'h8001, 4'd4,  2'b01, 16'h0010);
        run_one("rol_8001_4",  16'h8001, 4'd4,  2'b00, 16'h0018);
        run_one("rol_1234_15", 16'h1234, 4'd15, 2'b00, 16'h091A);
        run_one("sll_ffff_15", 16'hFFFF, 4'd15, 2'b01, 16'h8000);
        run_one("cnt0_op11",   16'h0001, 4'd0,  2'b11, 16'h0001);
        run_one("cnt0_op10",   16'hABCD, 4'd0,  2'b10, 16'hABCD);
`ifdef SHIFT_PIPE2_RIGHT_EN
        run_one("ror_0001_1",  16'h0001, 4'd1,  2'b10, 16'h8000);
        run_one("srl_f000_12", 16'hF000, 4'd12, 2'b11, 16'h000F);
`else
        run_one("ror_0001_1",  16'h0001, 4'd1,  2'b10, 16'h0002);
        run_one("srl_f000_12", 16'hF000, 4'd12, 2'b11, 16'h0000);
`endif

        // Back-to-back, out_ready high: results on consecutive cycles.
        out_ready = 1'b1; in_valid = 1'b1;
        In_d = 16'h0001; Cnt_d = 4'd1; Op_d = 2'b00;
        tick();
        In_d = 16'h0001; Cnt_d = 4'd2; Op_d = 2'b01;
        @(negedge clk);
        check("b2b_lat", {15'b0, out_valid}, 16'h0000);
        tick();
        In_d = 16'h8000; Cnt_d = 4'd1; Op_d = 2'b00;
        @(negedge clk);
        check("b2b_r1", Out_d, 16'h0002);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_r2", Out_d, 16'h0004);
        check("b2b_r2_valid", {15'b0, out_valid}, 16'h0001);
        @(negedge clk);
        check("b2b_r3", Out_d, 16'h0001);
        check("b2b_r3_valid", {15'b0, out_valid}, 16'h0001);
        @(negedge clk);
        check("b2b_empty", {15'b0, out_valid}, 16'h0000);
        tick();

        // Stall: fill both stages, hold 4 cycles, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1;
        In_d = 16'h1234; Cnt_d = 4'd0; Op_d = 2'b00;
        tick();
        In_d = 16'h00FF; Cnt_d = 4'd8; Op_d = 2'b01;
        tick();
        In_d = 16'h0F0F; Cnt_d = 4'd4; Op_d = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_in_ready", {15'b0, in_ready}, 16'h0000);
            check("stall_out", Out_d, 16'h1234);
            tick();
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && got.size() < 3; k++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc = 1'b1;
            if (out_valid && out_ready) got.push_back(Out_d);
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("stall_drain_count", 16'(got.size()), 16'd3);
        want[0] = 16'h1234; want[1] = 16'hFF00; want[2] = 16'hF0F0;
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) check($sformatf("stall_drain_%0d", k), got[k], want[k]);
        end
        in_valid = 1'b0;
        tick();

        // Reset with both stages full: in-flight results are discarded.
        out_ready = 1'b0; in_valid = 1'b1;
        In_d = 16'hAAAA; Cnt_d = 4'd1; Op_d = 2'b01;
        tick();
        In_d = 16'h5555; Cnt_d = 4'd3; Op_d = 2'b00;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_full", {15'b0, out_valid}, 16'h0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", {15'b0, out_valid}, 16'h0000);
        check("mid_rst_in_ready", {15'b0, in_ready}, 16'h0001);
        check("mid_rst_out", Out_d, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("mid_rst_no_stale", {15'b0, out_valid}, 16'h0000);
        end
        tick();
        run_one("post_mid_rst", 16'h8001, 4'd1, 2'b00, 16'h0003);

        repeat (2) tick();
        check("final_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
